// File: rtl/partition_sweep_pkg.sv
// Shared types and width helpers for the partition sweep controller.
//   state_t  : sweep sequencer states
//   hd_w     : bits needed to hold a Hamming distance of NUM_OUT bits
//   hdsum_w  : Hamming-distance sum width over a full 2^NUM_IN sweep
//   abs_w    : absolute numeric error sum width over a full sweep
package partition_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned hd_w(input int unsigned num_out);
        return $clog2(num_out + 1);
    endfunction

    function automatic int unsigned hdsum_w(input int unsigned num_in, input int unsigned num_out);
        return num_in + hd_w(num_out);
    endfunction

    function automatic int unsigned abs_w(input int unsigned num_in, input int unsigned num_out);
        return num_in + num_out;
    endfunction

endpackage

// File: rtl/hd_popcount.sv
// Combinational Hamming distance between exact and approximate outputs.
//   i_exact  : exact partition output
//   i_approx : approximate partition output
//   o_hd_c   : popcount(i_exact ^ i_approx)
module hd_popcount
    import partition_sweep_pkg::*;
#(
    parameter  int unsigned NUM_OUT = 4,
    localparam int unsigned HD_W    = hd_w(NUM_OUT)
) (
    input  logic [NUM_OUT-1:0] i_exact,
    input  logic [NUM_OUT-1:0] i_approx,
    output logic [HD_W-1:0]    o_hd_c
);

    logic [NUM_OUT-1:0] w_diff;

    // Count differing bit positions
    always_comb begin
        w_diff = i_exact ^ i_approx;
        o_hd_c = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            o_hd_c = o_hd_c + HD_W'(w_diff[i]);
        end
    end

endmodule

// File: rtl/partition_sweep_ctrl.sv
// Exhaustive sweep of a combinational partition: drives every input pattern
// in ascending order to an exact and an approximate implementation, waits
// SETTLE cycles, then accumulates error metrics from both outputs.
//   clk, rst_n        : clock, async active-low reset
//   start, abort      : begin sweep (IDLE/DONE only), terminate running sweep
//   pi                : pattern driven to both partitions
//   po_exact/approx   : partition outputs
//   busy, done        : RUN indicator, level completion flag
//   err_count, hd_sum, max_hd, abs_err_sum, first_err_pat/valid : metrics
module partition_sweep_ctrl
    import partition_sweep_pkg::*;
#(
    parameter  int unsigned NUM_IN  = 7,
    parameter  int unsigned NUM_OUT = 4,
    parameter  int unsigned SETTLE  = 1,
    localparam int unsigned HD_W    = hd_w(NUM_OUT),
    localparam int unsigned HDSUM_W = hdsum_w(NUM_IN, NUM_OUT),
    localparam int unsigned ABS_W   = abs_w(NUM_IN, NUM_OUT),
    localparam int unsigned ERR_W   = NUM_IN + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [NUM_IN-1:0]  pi,
    input  logic [NUM_OUT-1:0] po_exact,
    input  logic [NUM_OUT-1:0] po_approx,
    output logic               busy,
    output logic               done,
    output logic [ERR_W-1:0]   err_count,
    output logic [HDSUM_W-1:0] hd_sum,
    output logic [HD_W-1:0]    max_hd,
    output logic [ABS_W-1:0]   abs_err_sum,
    output logic [NUM_IN-1:0]  first_err_pat,
    output logic               first_err_valid
);

    localparam int unsigned CNT_W = (SETTLE == 0) ? 1 : $clog2(SETTLE + 1);

    state_t               r_state, w_state_nxt;
    logic [NUM_IN-1:0]    r_pi, w_pi_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [ERR_W-1:0]     r_err, w_err_nxt;
    logic [HDSUM_W-1:0]   r_hd_sum, w_hd_sum_nxt;
    logic [HD_W-1:0]      r_max_hd, w_max_hd_nxt;
    logic [ABS_W-1:0]     r_abs, w_abs_nxt;
    logic [NUM_IN-1:0]    r_first_pat, w_first_pat_nxt;
    logic                 r_first_valid, w_first_valid_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;

    logic [HD_W-1:0]      w_hd;
    logic                 w_mis;
    logic                 w_sample;
    logic [NUM_OUT:0]     w_diff;
    logic [NUM_OUT:0]     w_diff_neg;
    logic [NUM_OUT-1:0]   w_abs_diff;

    hd_popcount #(.NUM_OUT(NUM_OUT)) u_hd (
        .i_exact  (po_exact),
        .i_approx (po_approx),
        .o_hd_c   (w_hd)
    );

    // Signed difference one bit wider than the outputs, then magnitude
    always_comb begin
        w_mis      = (po_exact != po_approx);
        w_diff     = {1'b0, po_exact} - {1'b0, po_approx};
        w_diff_neg = -w_diff;
        w_abs_diff = w_diff[NUM_OUT] ? w_diff_neg[NUM_OUT-1:0] : w_diff[NUM_OUT-1:0];
    end

    // State and datapath register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pi          <= '0;
            r_cnt         <= '0;
            r_err         <= '0;
            r_hd_sum      <= '0;
            r_max_hd      <= '0;
            r_abs         <= '0;
            r_first_pat   <= '0;
            r_first_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pi          <= w_pi_nxt;
            r_cnt         <= w_cnt_nxt;
            r_err         <= w_err_nxt;
            r_hd_sum      <= w_hd_sum_nxt;
            r_max_hd      <= w_max_hd_nxt;
            r_abs         <= w_abs_nxt;
            r_first_pat   <= w_first_pat_nxt;
            r_first_valid <= w_first_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        w_state_nxt       = r_state;
        w_pi_nxt          = r_pi;
        w_cnt_nxt         = r_cnt;
        w_err_nxt         = r_err;
        w_hd_sum_nxt      = r_hd_sum;
        w_max_hd_nxt      = r_max_hd;
        w_abs_nxt         = r_abs;
        w_first_pat_nxt   = r_first_pat;
        w_first_valid_nxt = r_first_valid;
        w_busy_nxt        = r_busy;
        w_done_nxt        = r_done;
        w_sample          = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt       = RUN;
                    w_pi_nxt          = '0;
                    w_cnt_nxt         = '0;
                    w_err_nxt         = '0;
                    w_hd_sum_nxt      = '0;
                    w_max_hd_nxt      = '0;
                    w_abs_nxt         = '0;
                    w_first_pat_nxt   = '0;
                    w_first_valid_nxt = 1'b0;
                    w_busy_nxt        = 1'b1;
                    w_done_nxt        = 1'b0;
                end
            end
            RUN: begin
                w_sample = (r_cnt == CNT_W'(SETTLE));
                // A sample coinciding with abort is still accumulated
                if (w_sample) begin
                    w_err_nxt    = r_err + ERR_W'(w_mis);
                    w_hd_sum_nxt = r_hd_sum + HDSUM_W'(w_hd);
                    w_abs_nxt    = r_abs + ABS_W'(w_abs_diff);
                    if (w_hd > r_max_hd) begin
                        w_max_hd_nxt = w_hd;
                    end
                    if (w_mis && !r_first_valid) begin
                        w_first_pat_nxt   = r_pi;
                        w_first_valid_nxt = 1'b1;
                    end
                end
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (w_sample) begin
                    if (&r_pi) begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_pi_nxt  = r_pi + NUM_IN'(1);
                        w_cnt_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign pi              = r_pi;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err_count       = r_err;
    assign hd_sum          = r_hd_sum;
    assign max_hd          = r_max_hd;
    assign abs_err_sum     = r_abs;
    assign first_err_pat   = r_first_pat;
    assign first_err_valid = r_first_valid;

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Scoreboard bench for partition_sweep_ctrl with default parameters.
// Partitions are modelled behaviourally: exact = pi[6:4]+pi[3:1]+pi[0],
// approximate = per-pattern lookup table filled for each scenario.
module tb_partition_sweep_ctrl;

    localparam int NP        = 128;
    localparam int SWEEP_CYC = 256;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [6:0]  pi;
    logic [3:0]  po_exact;
    logic [3:0]  po_approx;
    logic        busy;
    logic        done;
    logic [7:0]  err_count;
    logic [9:0]  hd_sum;
    logic [2:0]  max_hd;
    logic [10:0] abs_err_sum;
    logic [6:0]  first_err_pat;
    logic        first_err_valid;

    typedef struct {
        int done;
        int pi;
        int err;
        int hds;
        int maxhd;
        int abs;
        int fpat;
        int fval;
        int cyc;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] appr[NP];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    partition_sweep_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .pi              (pi),
        .po_exact        (po_exact),
        .po_approx       (po_approx),
        .busy            (busy),
        .done            (done),
        .err_count       (err_count),
        .hd_sum          (hd_sum),
        .max_hd          (max_hd),
        .abs_err_sum     (abs_err_sum),
        .first_err_pat   (first_err_pat),
        .first_err_valid (first_err_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] exact_of(input int p);
        return 4'(((p >> 4) & 7) + ((p >> 1) & 7) + (p & 1));
    endfunction

    always_comb begin
        po_exact  = exact_of(int'(pi));
        po_approx = appr[pi];
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: metrics over the first npat patterns in ascending order
    function automatic exp_t model(input int npat, input int end_pi, input int end_done);
        exp_t r;
        r = '{default: 0};
        r.pi   = end_pi;
        r.done = end_done;
        for (int p = 0; p < npat; p++) begin
            int e, a, hd;
            e  = int'(exact_of(p));
            a  = int'(appr[p]);
            hd = $countones(e ^ a);
            if (e != a) begin
                r.err++;
                if (r.fval == 0) begin
                    r.fval = 1;
                    r.fpat = p;
                end
            end
            r.hds += hd;
            if (hd > r.maxhd) r.maxhd = hd;
            r.abs += (e > a) ? (e - a) : (a - e);
        end
        return r;
    endfunction

    // Monitor: every busy falling edge pops one expected result
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (prev_busy && !busy) begin
            if (sb_q.size() == 0) begin
                check("unexpected_end", 1, 0);
            end else begin
                x = sb_q.pop_front();
                check("done",            done,            x.done);
                check("pi",              pi,              x.pi);
                check("err_count",       err_count,       x.err);
                check("hd_sum",          hd_sum,          x.hds);
                check("max_hd",          max_hd,          x.maxhd);
                check("abs_err_sum",     abs_err_sum,     x.abs);
                check("first_err_pat",   first_err_pat,   x.fpat);
                check("first_err_valid", first_err_valid, x.fval);
                if (x.cyc != 0) check("done_cycle", cyc, x.cyc);
            end
        end
        prev_busy <= busy;
    end

    task automatic fill(input int mode);
        for (int p = 0; p < NP; p++) begin
            case (mode)
                0:       appr[p] = exact_of(p);
                1:       appr[p] = exact_of(p) ^ 4'b0001;
                2:       appr[p] = 4'd0;
                3:       appr[p] = (p == 'h5A) ? (exact_of(p) ^ 4'b0110) : exact_of(p);
                default: appr[p] = 4'($urandom_range(0, 15));
            endcase
        end
    endtask

    task automatic do_start(output int c);
        @(negedge clk);
        start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
        check("err_cleared", err_count, 0);
    endtask

    task automatic wait_done(input bit pulses);
        for (int i = 0; i < SWEEP_CYC + 20 && !done; i++) begin
            start = pulses ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_timeout", done, 1);
    endtask

    task automatic run_sweep(input int mode, input bit pulses);
        exp_t x;
        int   c;
        fill(mode);
        x = model(NP, 'h7F, 1);
        do_start(c);
        x.cyc = c + SWEEP_CYC + 1;
        sb_q.push_back(x);
        wait_done(pulses);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        int   c;
        fill(0);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pi", pi, 0);
        check("rst_err", err_count, 0);
        check("rst_fval", first_err_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 0);
        run_sweep(1, 0);
        run_sweep(2, 0);
        run_sweep(3, 0);
        run_sweep(3, 0);

        // abort is ignored once DONE
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_done_done", done, 1);
        check("abort_in_done_err", err_count, 1);

        // abort while pi = 0x20, before that pattern is sampled
        fill(4);
        x = model('h20, 'h20, 0);
        do_start(c);
        sb_q.push_back(x);
        for (int i = 0; i < 200 && pi != 7'h20; i++) @(negedge clk);
        check("abort_reach_pi", pi, 'h20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pi_hold", pi, 'h20);
        check("abort_busy", busy, 0);

        // start pulses during RUN must not disturb results or timing
        run_sweep(4, 1);

        // asynchronous reset mid-sweep
        fill(4);
        do_start(c);
        repeat (50) @(negedge clk);
        x = '{default: 0};
        sb_q.push_back(x);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_pi", pi, 0);
        check("rst_async_hd_sum", hd_sum, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        run_sweep(1, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
